attopu_ctrl: RTL and testbench

Instruction sequencer and register file for the attopu core: the unit on the other side of the ALU port. It fetches 16-bit instructions over a request/acknowledge instruction-memory port, drives the ALU operation and operands, writes ALU results back into a 4×16 register file, and branches on the ALU's registered carry and zero flags. It connects to the ALU port-for-port at the core top level and does not instantiate it.

---
 rtl/attopu_ctrl.sv | 142 ++++++++++++++
 tb/tb_attopu_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/attopu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : attopu_ctrl
// Purpose  : attopu instruction sequencer, 4x16 register file and ALU driver.
// Revision : 1.0 - initial release
// ============================================================================
module attopu_ctrl (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [6:0]  alu_op,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    input  logic [15:0] alu_out,
    input  logic        alu_c,
    input  logic        alu_z,
    output logic [7:0]  pc,
    output logic        halted,
    output logic        err,
    input  logic [1:0]  dbg_sel,
    output logic [15:0] dbg_data
);

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_EXEC   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_MVI  = 4'd2;
    localparam logic [3:0] OP_JMP  = 4'd3;
    localparam logic [3:0] OP_JZ   = 4'd4;
    localparam logic [3:0] OP_JC   = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd6;

    logic [1:0]  state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        err_q, err_d;
    logic [15:0] regs_q [4];
    logic [15:0] regs_d [4];

    logic [6:0]  alu_op_w;
    logic [15:0] alu_in1_w;
    logic [15:0] alu_in2_w;

    logic [3:0]  ir_op;
    logic [1:0]  ir_rd;
    logic [1:0]  ir_rs;
    logic [7:0]  ir_imm;

    assign ir_op  = ir_q[15:12];
    assign ir_rd  = ir_q[11:10];
    assign ir_rs  = ir_q[9:8];
    assign ir_imm = ir_q[7:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        err_d     = err_q;
        regs_d    = regs_q;
        alu_op_w  = 7'd0;
        alu_in1_w = 16'd0;
        alu_in2_w = 16'd0;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + 8'd1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (ir_op)
                    OP_MV: begin
                        alu_in1_w     = regs_q[ir_rs];
                        regs_d[ir_rd] = alu_out;
                    end
                    OP_ADD: begin
                        alu_op_w      = 7'd1;
                        alu_in1_w     = regs_q[ir_rd];
                        alu_in2_w     = regs_q[ir_rs];
                        regs_d[ir_rd] = alu_out;
                    end
                    OP_MVI: begin
                        alu_in1_w     = {{8{ir_imm[7]}}, ir_imm};
                        regs_d[ir_rd] = alu_out;
                    end
                    OP_JMP:  pc_d = ir_imm;
                    OP_JZ:   if (alu_z) pc_d = ir_imm;
                    OP_JC:   if (alu_c) pc_d = ir_imm;
                    OP_HALT: state_d = ST_HALTED;
                    default: begin
                        state_d = ST_HALTED;
                        err_d   = 1'b1;
                    end
                endcase
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FETCH;
        endcase
        // The ALU latches flags on any edge with op=1, so reset must mask it.
        if (rst) begin
            alu_op_w  = 7'd0;
            alu_in1_w = 16'd0;
            alu_in2_w = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= 8'd0;
            ir_q    <= 16'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) regs_q[i] <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
            regs_q  <= regs_d;
        end
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = (state_q == ST_HALTED);
    assign err       = err_q;
    assign alu_op    = alu_op_w;
    assign alu_in1   = alu_in1_w;
    assign alu_in2   = alu_in2_w;
    assign dbg_data  = regs_q[dbg_sel];

endmodule
`default_nettype wire

// File: tb/tb_attopu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_attopu_ctrl
// Purpose  : directed self-checking bench for attopu_ctrl with memory/ALU models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_attopu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [6:0]  alu_op;
    logic [15:0] alu_in1, alu_in2, alu_out;
    logic        alu_c = 1'b0;
    logic        alu_z = 1'b0;
    logic [7:0]  pc;
    logic        halted, err;
    logic [1:0]  dbg_sel = 2'd0;
    logic [15:0] dbg_data;

    logic [15:0] mem [256];
    int          wait_n = 0;
    int          wait_cnt = 0;
    logic        force_ack = 1'b0;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    int          op_cnt = 0;
    int          addr_viol = 0;
    logic [7:0]  log_addr [$];
    int          log_cyc [$];
    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [7:0]  prev_addr = 8'd0;

    always #5 clk = ~clk;

    attopu_ctrl u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
        .alu_c(alu_c), .alu_z(alu_z), .pc(pc), .halted(halted), .err(err),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    // Instruction memory with a programmable number of wait cycles per fetch
    assign imem_data = mem[imem_addr];
    assign imem_ack  = force_ack | (imem_req && (wait_cnt == wait_n));
    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= 0;
        else                              wait_cnt <= wait_cnt + 1;
    end

    // ALU model: MV passes in1, ADD sums; flags registered only when op=1
    wire [16:0] alu_sum = {1'b0, alu_in1} + {1'b0, alu_in2};
    assign alu_out = (alu_op == 7'd1) ? alu_sum[15:0] : alu_in1;
    always @(posedge clk) begin
        if (alu_op == 7'd1) begin
            alu_c <= alu_sum[16];
            alu_z <= (alu_sum[15:0] == 16'd0);
        end
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (alu_op == 7'd1) op_cnt = op_cnt + 1;
        if (imem_req && imem_ack && !rst) begin
            log_addr.push_back(imem_addr);
            log_cyc.push_back(cyc);
        end
        if (!rst && imem_req && prev_req && !prev_ack && imem_addr != prev_addr)
            addr_viol = addr_viol + 1;
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic read_reg(input logic [1:0] s, output logic [15:0] v);
        dbg_sel = s;
        #1;
        v = dbg_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_fetch(input logic [7:0] a, input int max, input string tag);
        logic found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == a) found = 1'b1;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic wait_halt(input int max, input string tag);
        for (int i = 0; i < max && !halted; i++) @(negedge clk);
        check(tag, {31'd0, halted}, 32'd1);
    endtask

    task automatic load_prog(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        for (int i = 0; i < 256; i++) mem[i] = 16'h6000;
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
    endtask

    initial begin
        logic [15:0] v;
        int          base, op_base, viol_base;

        // Program A: MVI/ADD carry+zero, taken JZ, doubling ADD, not-taken JZ, HALT
        load_prog(16'h24FF, 16'h2801, 16'h1600);
        mem[8'h03] = 16'h4010;
        mem[8'h10] = 16'h2001;
        mem[8'h11] = 16'h1000;
        mem[8'h12] = 16'h4040;
        mem[8'h13] = 16'h6000;
        wait_n = 0;
        do_reset();
        #1;
        check("rst_req",    {31'd0, imem_req}, 32'd1);
        check("rst_addr",   {24'd0, imem_addr}, 32'd0);
        check("rst_aluop",  {25'd0, alu_op}, 32'd0);
        check("rst_in1",    {16'd0, alu_in1}, 32'd0);
        check("rst_in2",    {16'd0, alu_in2}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_err",    {31'd0, err}, 32'd0);
        for (int r = 0; r < 4; r++) begin
            read_reg(r[1:0], v);
            check("rst_reg", {16'd0, v}, 32'd0);
        end
        base    = log_addr.size();
        op_base = op_cnt;
        wait_fetch(8'h03, 20, "a_fetch3_to");
        read_reg(2'd1, v); check("a_r1_add", {16'd0, v}, 32'h0000);
        read_reg(2'd2, v); check("a_r2",     {16'd0, v}, 32'h0001);
        check("a_c", {31'd0, alu_c}, 32'd1);
        check("a_z", {31'd0, alu_z}, 32'd1);
        check("a_aluop_once", op_cnt - op_base, 32'd1);
        wait_fetch(8'h10, 10, "a_jz_taken_to");
        wait_halt(40, "a_halt_to");
        read_reg(2'd0, v); check("a_r0_double", {16'd0, v}, 32'h0002);
        check("a_z_after", {31'd0, alu_z}, 32'd0);
        check("a_err", {31'd0, err}, 32'd0);
        check("a_pc", {24'd0, pc}, 32'h14);
        check("a_nfetch", log_addr.size() - base, 32'd8);
        if (log_addr.size() - base == 8) begin
            check("a_log4", {24'd0, log_addr[base+4]}, 32'h10);
            check("a_log7_nottaken", {24'd0, log_addr[base+7]}, 32'h13);
            check("a_cpi", log_cyc[base+1] - log_cyc[base], 32'd2);
        end
        check("a_aluop_total", op_cnt - op_base, 32'd2);

        // Program B: 3-cycle fetch waits, MVI r1,5 ; MV r3,r1 ; HALT
        load_prog(16'h2405, 16'h0D00, 16'h6000);
        wait_n = 3;
        do_reset();
        base      = log_addr.size();
        op_base   = op_cnt;
        viol_base = addr_viol;
        wait_halt(60, "b_halt_to");
        read_reg(2'd3, v); check("b_r3_mv", {16'd0, v}, 32'h0005);
        check("b_aluop_zero", op_cnt - op_base, 32'd0);
        check("b_addr_stable", addr_viol - viol_base, 32'd0);
        check("b_flags", {30'd0, alu_c, alu_z}, 32'd0);
        if (log_addr.size() - base >= 3)
            check("b_mv_cycles", log_cyc[base+2] - log_cyc[base+1], 32'd5);
        else
            check("b_nfetch", log_addr.size() - base, 32'd3);

        // Program C: JMP 0xFF ; MV r0,r1 at 0xFF -> pc wraps to 0x00
        load_prog(16'h30FF, 16'h6000, 16'h6000);
        mem[8'hFF] = 16'h0100;
        wait_n = 0;
        do_reset();
        base = log_addr.size();
        repeat (10) @(negedge clk);
        if (log_addr.size() - base >= 3) begin
            check("c_jmp_ff", {24'd0, log_addr[base+1]}, 32'hFF);
            check("c_wrap",   {24'd0, log_addr[base+2]}, 32'h00);
        end else
            check("c_nfetch", log_addr.size() - base, 32'd3);

        // Program D: MVI r2,0x7F ; illegal 0xF000 -> halted with err, frozen
        load_prog(16'h287F, 16'hF000, 16'h6000);
        do_reset();
        wait_halt(20, "d_halt_to");
        check("d_err", {31'd0, err}, 32'd1);
        force_ack = 1'b1;
        v = 16'd0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (imem_req || alu_op != 7'd0) v = v + 16'd1;
        end
        force_ack = 1'b0;
        check("d_no_req", {16'd0, v}, 32'd0);
        check("d_pc_frozen", {24'd0, pc}, 32'd2);
        check("d_halted_held", {31'd0, halted}, 32'd1);
        read_reg(2'd2, v); check("d_r2_frozen", {16'd0, v}, 32'h007F);

        // Reset during a fetch wait
        load_prog(16'h2403, 16'h1500, 16'h6000);
        wait_n = 3;
        do_reset();
        wait_fetch(8'h01, 20, "e_fetch1_to");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("e_pc",  {24'd0, pc}, 32'd0);
        check("e_req", {31'd0, imem_req}, 32'd1);
        read_reg(2'd1, v); check("e_r1", {16'd0, v}, 32'd0);
        check("e_flags", {30'd0, alu_c, alu_z}, 32'd0);
        rst = 1'b0;

        // Reset in the EXEC cycle of ADD r1,r1 with r1=0xFF80 (would set carry)
        load_prog(16'h2480, 16'h1500, 16'h6000);
        wait_n = 0;
        do_reset();
        wait_fetch(8'h01, 10, "f_fetch1_to");
        @(negedge clk);
        check("f_in_add", {25'd0, alu_op}, 32'd1);
        rst = 1'b1;
        #1;
        check("f_aluop_masked", {25'd0, alu_op}, 32'd0);
        @(negedge clk);
        check("f_pc",  {24'd0, pc}, 32'd0);
        check("f_req", {31'd0, imem_req}, 32'd1);
        read_reg(2'd1, v); check("f_r1", {16'd0, v}, 32'd0);
        check("f_flags", {30'd0, alu_c, alu_z}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
